// File: rtl/monitor_erro.sv
// Fault monitor: synchronizes three sensor fault lines and an acknowledge button,
// debounces faults, latches a prioritized fault code and blinks ERRO until acknowledged.
module monitor_erro #(
  parameter int DEB_CICLOS   = 1000,
  parameter int PISCA_CICLOS = 25000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] SENSOR,
  input  logic       BTN_ACK,
  output logic       ERRO,
  output logic       EM_ERRO,
  output logic [1:0] ERRO_COD
);

  localparam int DEB_W = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
  localparam int PIS_W = (PISCA_CICLOS > 1) ? $clog2(PISCA_CICLOS) : 1;

  typedef enum logic [1:0] {
    OK         = 2'd0,
    FILTRANDO  = 2'd1,
    ERRO_ATIVO = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_sens_s1;
  logic [2:0]       r_sens_s2;
  logic             r_ack_s1;
  logic             r_ack_s2;
  logic             r_ack_s3;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [DEB_W-1:0] w_deb_nxt;
  logic [PIS_W-1:0] r_pisca_cnt;
  logic [PIS_W-1:0] w_pisca_nxt;
  logic             r_erro;
  logic             r_em_erro;
  logic [1:0]       r_cod;
  logic             w_erro_nxt;
  logic             w_em_erro_nxt;
  logic [1:0]       w_cod_nxt;
  logic             w_any;
  logic             w_ack;
  logic [1:0]       w_cod_prio;

  assign w_any = |r_sens_s2;
  assign w_ack = r_ack_s2 & ~r_ack_s3;

  always_comb begin
    w_cod_prio = 2'd0;
    if (r_sens_s2[0])      w_cod_prio = 2'd1;
    else if (r_sens_s2[1]) w_cod_prio = 2'd2;
    else if (r_sens_s2[2]) w_cod_prio = 2'd3;
  end

  // Input synchronizers; the third ack flop only feeds the rising-edge detector
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sens_s1 <= 3'b000;
      r_sens_s2 <= 3'b000;
      r_ack_s1  <= 1'b0;
      r_ack_s2  <= 1'b0;
      r_ack_s3  <= 1'b0;
    end else begin
      r_sens_s1 <= SENSOR;
      r_sens_s2 <= r_sens_s1;
      r_ack_s1  <= BTN_ACK;
      r_ack_s2  <= r_ack_s1;
      r_ack_s3  <= r_ack_s2;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= OK;
      r_deb_cnt   <= '0;
      r_pisca_cnt <= '0;
      r_erro      <= 1'b0;
      r_em_erro   <= 1'b0;
      r_cod       <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_deb_cnt   <= w_deb_nxt;
      r_pisca_cnt <= w_pisca_nxt;
      r_erro      <= w_erro_nxt;
      r_em_erro   <= w_em_erro_nxt;
      r_cod       <= w_cod_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = '0;
    case (r_state)
      OK: begin
        if (w_any) w_state_nxt = FILTRANDO;
      end
      FILTRANDO: begin
        if (!w_any)
          w_state_nxt = OK;
        else if (r_deb_cnt == DEB_W'(DEB_CICLOS - 1))
          w_state_nxt = ERRO_ATIVO;
        else
          w_deb_nxt = r_deb_cnt + DEB_W'(1);
      end
      ERRO_ATIVO: begin
        // An ack that arrives while a fault is still present is simply dropped
        if (w_ack && !w_any) w_state_nxt = OK;
      end
      default: w_state_nxt = OK;
    endcase
  end

  // Outputs are registered, so they are derived from the transition being taken
  always_comb begin
    w_erro_nxt    = 1'b0;
    w_em_erro_nxt = 1'b0;
    w_cod_nxt     = 2'd0;
    w_pisca_nxt   = '0;
    if (w_state_nxt == ERRO_ATIVO) begin
      if (r_state != ERRO_ATIVO) begin
        w_erro_nxt    = 1'b1;
        w_em_erro_nxt = 1'b1;
        w_cod_nxt     = w_cod_prio;
      end else begin
        w_em_erro_nxt = r_em_erro;
        w_cod_nxt     = r_cod;
        if (r_pisca_cnt == PIS_W'(PISCA_CICLOS - 1)) begin
          w_erro_nxt = ~r_erro;
        end else begin
          w_erro_nxt  = r_erro;
          w_pisca_nxt = r_pisca_cnt + PIS_W'(1);
        end
      end
    end
  end

  assign ERRO     = r_erro;
  assign EM_ERRO  = r_em_erro;
  assign ERRO_COD = r_cod;

endmodule
